// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port SRAM with one-cycle read latency.
// The data port has priority; ifetch is forced through after STARVE_LIMIT consecutive denials.
module mem_arbiter #(
    parameter int unsigned LEN_ADDR     = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [LEN_ADDR-1:0] if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [31:0]         if_rdata,

    input  logic                mem_req,
    input  logic [LEN_ADDR-1:0] mem_addr,
    input  logic [3:0]          mem_we,
    input  logic [31:0]         mem_wdata,
    output logic                mem_gnt,
    output logic                mem_rvalid,
    output logic [31:0]         mem_rdata,

    output logic [LEN_ADDR-1:0] sram_addr,
    output logic                sram_en,
    output logic [3:0]          sram_we,
    output logic [31:0]         sram_din,
    input  logic [31:0]         sram_dout
);

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2
    } owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       if_keep_q, if_keep_d;
    logic       force_if;

    always_comb begin
        force_if  = if_req && (starve_q == LIMIT);
        if_gnt    = !rst && if_req && (!mem_req || force_if);
        mem_gnt   = !rst && mem_req && !force_if;

        sram_en   = if_gnt || mem_gnt;
        sram_addr = '0;
        sram_we   = '0;
        sram_din  = '0;
        if (if_gnt) begin
            sram_addr = if_addr;
        end else if (mem_gnt) begin
            sram_addr = mem_addr;
            sram_we   = mem_we;
            sram_din  = mem_wdata;
        end

        if (if_req && !if_gnt) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
        end else begin
            starve_d = '0;
        end

        if (if_gnt) begin
            state_d = IF_RD;
        end else if (mem_gnt && (mem_we == 4'h0)) begin
            state_d = MEM_RD;
        end else begin
            state_d = NONE;
        end
        // A flush in the grant cycle is remembered so the response is dropped next cycle.
        if_keep_d = !if_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NONE;
            starve_q  <= '0;
            if_keep_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            if_keep_q <= if_keep_d;
        end
    end

    // Gating with rst drops a response whose grant preceded the reset cycle.
    assign if_rvalid  = !rst && (state_q == IF_RD) && if_keep_q && !if_flush;
    assign mem_rvalid = !rst && (state_q == MEM_RD);
    assign if_rdata   = sram_dout;
    assign mem_rdata  = sram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a stimulus process predicts grants and queues expected
// read responses; a monitor process pops them when the DUT raises rvalid.
module tb_mem_arbiter;

    localparam int unsigned LA     = 64;
    localparam int unsigned STARVE = 4;

    logic          clk;
    logic          rst;
    logic          if_req, if_flush, if_gnt, if_rvalid;
    logic [LA-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          mem_req, mem_gnt, mem_rvalid;
    logic [LA-1:0] mem_addr;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [LA-1:0] sram_addr;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [31:0]   sram_din, sram_dout;

    mem_arbiter #(.LEN_ADDR(LA), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .sram_addr(sram_addr), .sram_en(sram_en), .sram_we(sram_we), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_val(input int i);
        return 32'hA5C30000 ^ (32'(i) * 32'h01000193);
    endfunction

    // SRAM environment model: registered address, data one cycle later, reloads on reset.
    logic [31:0] sram_arr [256];
    logic [7:0]  sidx;
    assign sidx = sram_addr[9:2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) sram_arr[i] <= init_val(i);
        end else if (sram_en) begin
            if (sram_we == 4'h0) begin
                sram_dout <= sram_arr[sidx];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) sram_arr[sidx][8*b +: 8] <= sram_din[8*b +: 8];
            end
        end
    end

    typedef struct {
        int          c;
        logic [31:0] d;
    } rsp_t;

    rsp_t        exp_if[$];
    rsp_t        exp_mem[$];
    logic [31:0] ref_mem [256];
    int          wait_cnt;
    int          cyc;
    int          checks;
    int          errors;
    logic [5:0]  pat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, then predict and check the combinational grant side.
    task automatic step(input logic r, input logic ireq, input logic [63:0] ia, input logic fl,
                        input logic mreq, input logic [63:0] ma, input logic [3:0] we,
                        input logic [31:0] wd);
        logic        e_if, e_mem;
        logic [63:0] e_addr;
        logic [7:0]  idx;
        rsp_t        r_item;
        @(negedge clk);
        rst = r; if_req = ireq; if_addr = ia; if_flush = fl;
        mem_req = mreq; mem_addr = ma; mem_we = we; mem_wdata = wd;
        cyc++;
        #2;
        // Ifetch wins if it is alone or has already been refused STARVE cycles in a row.
        e_if   = !r && ireq && (!mreq || wait_cnt >= STARVE);
        e_mem  = !r && mreq && !e_if;
        e_addr = e_if ? ia : (e_mem ? ma : 64'h0);

        chk("if_gnt", {63'h0, if_gnt}, {63'h0, e_if});
        chk("mem_gnt", {63'h0, mem_gnt}, {63'h0, e_mem});
        chk("gnt_exclusive", {63'h0, if_gnt & mem_gnt}, 64'h0);
        chk("sram_en", {63'h0, sram_en}, {63'h0, e_if | e_mem});
        chk("sram_addr", sram_addr, e_addr);
        chk("sram_we", {60'h0, sram_we}, {60'h0, (e_mem ? we : 4'h0)});
        if (e_mem) chk("sram_din", {32'h0, sram_din}, {32'h0, wd});

        if (r) wait_cnt = 0;
        else if (ireq && !e_if) wait_cnt = (wait_cnt + 1 > STARVE) ? STARVE : wait_cnt + 1;
        else wait_cnt = 0;

        if ((fl || r) && exp_if.size() > 0 && exp_if[0].c == cyc) void'(exp_if.pop_front());
        if (r && exp_mem.size() > 0 && exp_mem[0].c == cyc) void'(exp_mem.pop_front());
        if (r) for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        if (e_if && !fl) begin
            idx = ia[9:2];
            r_item.c = cyc + 1; r_item.d = ref_mem[idx];
            exp_if.push_back(r_item);
        end
        if (e_mem) begin
            idx = ma[9:2];
            if (we == 4'h0) begin
                r_item.c = cyc + 1; r_item.d = ref_mem[idx];
                exp_mem.push_back(r_item);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (we[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 4'h0, 32'h0);
    endtask

    function automatic logic [63:0] raddr();
        return {$urandom(), $urandom()};
    endfunction

    // Monitor: compares each rvalid against the oldest queued expectation.
    initial begin
        rsp_t rsp;
        forever begin
            @(negedge clk);
            #3;
            if (if_rvalid) begin
                if (exp_if.size() > 0 && exp_if[0].c == cyc) begin
                    rsp = exp_if.pop_front();
                    chk("if_rdata", {32'h0, if_rdata}, {32'h0, rsp.d});
                end else begin
                    chk("if_rvalid_unexpected", {63'h0, if_rvalid}, 64'h0);
                end
            end else if (exp_if.size() > 0 && exp_if[0].c == cyc) begin
                void'(exp_if.pop_front());
                chk("if_rvalid_missing", {63'h0, if_rvalid}, 64'h1);
            end
            if (mem_rvalid) begin
                if (exp_mem.size() > 0 && exp_mem[0].c == cyc) begin
                    rsp = exp_mem.pop_front();
                    chk("mem_rdata", {32'h0, mem_rdata}, {32'h0, rsp.d});
                end else begin
                    chk("mem_rvalid_unexpected", {63'h0, mem_rvalid}, 64'h0);
                end
            end else if (exp_mem.size() > 0 && exp_mem[0].c == cyc) begin
                void'(exp_mem.pop_front());
                chk("mem_rvalid_missing", {63'h0, mem_rvalid}, 64'h1);
            end
        end
    end

    initial begin
        logic [3:0] we;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_addr = '0; mem_we = '0; mem_wdata = '0;
        cyc = 0; checks = 0; errors = 0; wait_cnt = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        // Reset with requests pending: no grants allowed.
        step(1'b1, 1'b1, 64'h40, 1'b0, 1'b1, 64'h80, 4'h0, 32'h0);
        step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 4'h0, 32'h0);
        idle();

        // Lone ifetch at 0x1000.
        step(1'b0, 1'b1, 64'h1000, 1'b0, 1'b0, 64'h0, 4'h0, 32'h0);
        idle();

        // Both ports held six cycles: ifetch forced through on the fifth.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, raddr(), 1'b0, 1'b1, raddr(), 4'h0, 32'h0);
            pat[i] = if_gnt;
        end
        chk("starve_pattern", {58'h0, pat}, 64'h10);
        idle();

        // Partial write followed by a read of the same word.
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h24, 4'b0011, 32'hDEADBEEF);
        idle();
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h24, 4'h0, 32'h0);
        idle();

        // Ifetch grant, then flush in the response cycle alongside a data read.
        step(1'b0, 1'b1, raddr(), 1'b0, 1'b0, 64'h0, 4'h0, 32'h0);
        step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, raddr(), 4'h0, 32'h0);
        idle();
        // Flush during the grant cycle itself.
        step(1'b0, 1'b1, raddr(), 1'b1, 1'b0, 64'h0, 4'h0, 32'h0);
        idle();

        // Data read, then reset in its response cycle; starvation restarts from zero after.
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, raddr(), 4'h0, 32'h0);
        step(1'b1, 1'b1, raddr(), 1'b0, 1'b1, raddr(), 4'h0, 32'h0);
        idle();
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, raddr(), 1'b0, 1'b1, raddr(), 4'h0, 32'h0);
        idle();

        // Alternating single requests every cycle.
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) begin
                step(1'b0, 1'b1, raddr(), 1'b0, 1'b0, 64'h0, 4'h0, 32'h0);
            end else begin
                we = ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0;
                step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, raddr(), we, $urandom());
            end
        end

        // Fully random traffic with occasional flushes and resets.
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'h0;
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), raddr(),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), raddr(),
                 we, $urandom());
        end

        idle();
        idle();
        idle();
        chk("if_queue_drained", 64'(exp_if.size()), 64'h0);
        chk("mem_queue_drained", 64'(exp_mem.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LEN_ADDR, default 64, request/SRAM address width in bits.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive ifetch denials before ifetch is forced to win; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port if_req  input  1  ifetch read request.
REQ-006 SHALL have port if_addr  input  LEN_ADDR  ifetch byte address.
REQ-007 SHALL have port if_flush  input  1  discard any ifetch response due next cycle.
REQ-008 SHALL have port if_gnt  output  1  ifetch request accepted this cycle.
REQ-009 SHALL have port if_rvalid  output  1  ifetch read data valid.
REQ-010 SHALL have port if_rdata  output  32  ifetch read data.
REQ-011 SHALL have port mem_req  input  1  data-port request.
REQ-012 SHALL have port mem_addr  input  LEN_ADDR  data-port byte address.
REQ-013 SHALL have port mem_we  input  4  byte write enables; 0 means read.
REQ-014 SHALL have port mem_wdata  input  32  write data.
REQ-015 SHALL have port mem_gnt  output  1  data request accepted this cycle.
REQ-016 SHALL have port mem_rvalid  output  1  data read data valid.
REQ-017 SHALL have port mem_rdata  output  32  data read data.
REQ-018 SHALL have SRAM-side ports sram_addr (output, LEN_ADDR), sram_en (output, 1), sram_we (output, 4), sram_din (output, 32) and sram_dout (input, 32), for a single-port SRAM that registers its address and returns data one cycle later.

Function
REQ-019 SHALL serve at most one request per cycle; the grant is combinational in the request cycle, and if_gnt and mem_gnt are never both 1.
REQ-020 SHALL use default priority: the data port wins when both if_req and mem_req are 1.
REQ-021 SHALL keep a starvation counter (4 bits, saturating at STARVE_LIMIT).
  - Increments each cycle with if_req=1 and if_gnt=0.
  - Clears on any cycle with if_gnt=1 or if_req=0.
REQ-022 SHALL grant ifetch when the starvation counter equals STARVE_LIMIT and if_req=1, even if mem_req=1.
REQ-023 SHALL drive the SRAM from the granted requester in the same cycle: sram_en=1, sram_addr/sram_we/sram_din from the winner; sram_we=0 for an ifetch grant.
REQ-024 SHALL drive sram_en=0, sram_we=0 and sram_addr=0 when no request is granted.
REQ-025 SHALL track the response owner in a registered 2-bit state machine.
  - States: NONE, IF_RD, MEM_RD.
  - Next state is IF_RD on an ifetch grant, MEM_RD on a data-read grant (mem_we=0), and NONE otherwise (including data writes).
REQ-026 SHALL assert if_rvalid=1 in the cycle after an ifetch grant (state IF_RD), unless if_flush was 1 in the grant cycle or is 1 in the response cycle.
REQ-027 SHALL assert mem_rvalid=1 exactly one cycle after a data-read grant (state MEM_RD); writes produce no rvalid.
REQ-028 SHALL drive if_rdata and mem_rdata directly from sram_dout; they are meaningful only when the matching rvalid is 1.
REQ-029 SHALL support back-to-back grants every cycle; the response of grant N coincides with grant N+1 with no bubble.
REQ-030 SHALL discard only the ifetch response on if_flush; the data port, state register and starvation counter are unaffected, and an ifetch request in the flush cycle may still be granted.
REQ-031 SHALL treat a held request as a new request every cycle; a requester that wants one access deasserts req after its gnt.

Reset
REQ-032 SHALL, while rst=1, force if_gnt=0, mem_gnt=0, sram_en=0 and sram_we=0 regardless of requests.
REQ-033 SHALL, on a clock edge with rst=1, set state=NONE and starvation counter=0, so if_rvalid=0 and mem_rvalid=0 in the first cycle after reset.
REQ-034 SHALL drop a grant issued in the cycle before rst rises: no rvalid for it appears after reset.

Verification
REQ-035 SHALL be verified with: if_req=1 at 0x1000 alone -> if_gnt=1 and sram_addr=0x1000 that cycle; if_rvalid=1 next cycle with if_rdata=sram_dout.
REQ-036 SHALL be verified with: if_req and mem_req (read) both held for 6 cycles, STARVE_LIMIT=4 -> mem_gnt in cycles 0-3, if_gnt in cycle 4, mem_gnt in cycle 5; rvalid follows the owner one cycle later.
REQ-037 SHALL be verified with: mem_req, mem_we=4'b0011, wdata=0xDEADBEEF -> sram_we=0011, sram_din=0xDEADBEEF, mem_gnt=1; mem_rvalid stays 0 next cycle.
REQ-038 SHALL be verified with: ifetch grant in cycle N and if_flush=1 in cycle N+1 -> if_rvalid=0 in N+1; a mem read granted in N+1 gives mem_rvalid=1 in N+2.
REQ-039 SHALL be verified with: data-read grant in cycle N and rst=1 in cycle N+1 -> mem_rvalid=0 in N+1 and N+2, all gnt=0 during rst, counter=0 afterwards.
REQ-040 SHALL be verified with: alternating if/mem single requests every cycle for 100 cycles, random data -> every grant yields exactly one matching rvalid (reads only), never both gnts high.
